pipelined_cla_adder: RTL
========================

Name: pipelined_cla_adder

Overview:
- Parametrised two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshaking on both sides.
- Successor to the fixed 4-bit CLA adder: arbitrary width (multiple of 4), add/sub mode, full flag set, optional signed saturation.
- Feeds the ALU execute stage and the address-generation path; stalls cleanly under downstream backpressure.

Parameters:
- WIDTH, 16, operand/result width; multiple of 4, 8..64 (elaboration error otherwise).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_a  in  WIDTH  operand A (two's complement)
- in_b  in  WIDTH  operand B
- in_sub  in  1  1 = A - B, 0 = A + B
- in_sat  in  1  request signed saturation (ignored unless macro enabled)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of MSB (sub: 1 = no borrow)
- out_ovfl  out  1  signed overflow (carry into MSB xor carry out of MSB), pre-saturation
- out_zero  out  1  out_sum == 0 (post-saturation)

Behaviour:
- Transfer: a beat moves when valid && ready on the same edge.
- Arithmetic: effective B = in_sub ? ~in_b : in_b; cin = in_sub.
  - Operand split into 4-bit CLA groups; each group produces per-bit carries plus group P (AND of bit propagates) and group G (gen3 | g2·p3 | g1·p3·p2 | g0·p3·p2·p1).
  - Group carries chain across groups via G | P·cin_group.
- Stage 1 (S1), registered: low WIDTH/2 sum bits, carry out of the low half, high-half operands, in_sub, in_sat.
- Stage 2 (S2), registered: high half from the S1 carry; cout, ovfl, saturation, zero.
- Latency: exactly 2 cycles from accept to out_valid with no stalls. Throughput 1 beat/cycle.
- Ready chain (combinational):
  - s2_ready = !s2_valid || out_ready
  - s1_ready = !s1_valid || s2_ready
  - in_ready = s1_ready && !rst
- Stall: a stage holds its data and valid while its downstream ready is 0. out_* stable while out_valid && !out_ready.
- Simultaneous accept and drain on a full pipe: allowed, no bubble, no loss.
- Reset values: out_valid=0, out_sum=0, out_cout=0, out_ovfl=0, out_zero=0, all internal valids 0.
- Reset mid-operation: in-flight beats discarded; out_valid=0 the cycle after rst is sampled high.
- Wrap-around: without saturation, the result wraps modulo 2^WIDTH. 0x7FFF+1 gives 0x8000 with ovfl=1.

Optional Feature:
- Macro PIPELINED_CLA_ADDER_SAT_EN.
- Defined: if in_sat && ovfl, out_sum = A_msb ? {1'b1, {WIDTH-1{0}}} : {1'b0, {WIDTH-1{1}}}. out_ovfl still reports raw overflow; out_zero reflects the saturated value.
- Undefined: in_sat is ignored (not registered) and the result always wraps. Port list is unchanged.

Decomposition:
- Package adder_pkg: localparam CLA_GROUP_W = 4; typedef struct for S1 payload (low sum, half carry, high operands, sub, sat); function sat_value(sign, width).
- One sub-module: cla_group4 (4-bit lookahead: a, b, cin -> per-bit carries, group P, group G). Instantiate WIDTH/4 copies via generate.

Test Plan:
- WIDTH=16, add 0x1234 + 0x0FFF, out_ready=1 -> out_valid 2 cycles later, sum 0x2233, cout 0, ovfl 0, zero 0.
- Sub 0x0005 - 0x0005 -> sum 0x0000, cout 1, ovfl 0, zero 1. Sub 0x0000 - 0x0001 -> sum 0xFFFF, cout 0.
- Add 0x7FFF + 0x0001, sat=1: macro on -> sum 0x7FFF, ovfl 1; macro off -> sum 0x8000, ovfl 1. Sub 0x8000 - 0x0001, sat=1, macro on -> sum 0x8000, ovfl 1.
- Back-to-back: 4 beats on consecutive cycles with out_ready held 0 -> in_ready drops after 2 beats accepted. Release out_ready -> results emerge in order, no loss or duplication.
- Carry across the half boundary: 0x00FF + 0x0001 -> 0x0100; 0xFFFF + 0x0001 -> 0x0000, cout 1, zero 1. Repeat at WIDTH=8 and WIDTH=64 with random operands against a behavioural model.
- rst asserted while 2 beats are in flight -> out_valid 0 the next cycle, no stale result after rst deasserts; in_ready 0 during rst.

Source files
------------

// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants, stage-1 control flags and the saturation helper for pipelined_cla_adder.
// Build option: PIPELINED_CLA_ADDER_SAT_EN adds the registered saturation request.
package adder_pkg;

   localparam int unsigned CLA_GROUP_W = 4;
   localparam int unsigned MAX_WIDTH   = 64;

   // Width-independent part of the stage-1 payload; the sized fields live in the top.
   typedef struct packed {
      logic half_cout;
      logic sub;
`ifdef PIPELINED_CLA_ADDER_SAT_EN
      logic sat;
`endif
   } s1_ctrl_t;

   // Most negative value when sign is set, most positive otherwise, for a width-bit word.
   function automatic logic [MAX_WIDTH-1:0] sat_value(input logic sign, input int unsigned width);
      logic [MAX_WIDTH-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
         if (i + 1 < width)
            v[i] = ~sign;
         else if (i + 1 == width)
            v[i] = sign;
      end
      return v;
   endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_group4.sv
// 4-bit carry-lookahead group: internal bit carries plus group propagate/generate.
module cla_group4
   import adder_pkg::*;
(
   input  logic [CLA_GROUP_W-1:0] a,
   input  logic [CLA_GROUP_W-1:0] b,
   input  logic                   cin,
   output logic [CLA_GROUP_W-2:0] c,
   output logic                   p,
   output logic                   g
);

   logic [CLA_GROUP_W-1:0] bp;
   logic [CLA_GROUP_W-1:0] bg;

   assign bp = a ^ b;
   assign bg = a & b;

   // c[i] is the carry out of bit i; the group carry out is formed by the caller from p/g.
   assign c[0] = bg[0] | (bp[0] & cin);
   assign c[1] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & cin);
   assign c[2] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0]) | (bp[2] & bp[1] & bp[0] & cin);

   assign p = &bp;
   assign g = bg[3] | (bg[2] & bp[3]) | (bg[1] & bp[3] & bp[2]) | (bg[0] & bp[3] & bp[2] & bp[1]);

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined CLA adder/subtractor with valid/ready on both sides.
// Build option: PIPELINED_CLA_ADDER_SAT_EN enables signed saturation via in_sat.
module pipelined_cla_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovfl,
   output logic             out_zero
);

   localparam int unsigned HALF = WIDTH / 2;
   localparam int unsigned PW   = ((HALF + CLA_GROUP_W - 1) / CLA_GROUP_W) * CLA_GROUP_W;
   localparam int unsigned NGH  = PW / CLA_GROUP_W;

   if ((WIDTH % CLA_GROUP_W) != 0 || WIDTH < 8 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("pipelined_cla_adder: WIDTH must be a multiple of 4 in 8..64");
   end

   typedef struct packed {
      logic [HALF-1:0] sum_lo;
      logic [HALF-1:0] a_hi;
      logic [HALF-1:0] b_hi;
      s1_ctrl_t        ctrl;
   } s1_payload_t;

   logic            s1_valid, s2_valid, s1_ready, s2_ready;
   s1_payload_t     s1_q, s1_d;
   logic [HALF-1:0] b_lo_eff, b_hi_eff;
   logic [1:0][PW-1:0] h_a, h_b, h_sum;
   logic [1:0]      h_cin, h_cout;
   logic            hi_cmsb;
   logic [WIDTH-1:0] sum_d;
   logic            ovfl_d;

   assign s2_ready = !s2_valid || out_ready;
   assign s1_ready = !s1_valid || s2_ready;
   assign in_ready = s1_ready && !rst;

   // Half 0 adds the live low operands; half 1 adds the registered high operands.
   assign b_lo_eff = in_sub ? ~in_b[HALF-1:0] : in_b[HALF-1:0];
   assign b_hi_eff = s1_q.ctrl.sub ? ~s1_q.b_hi : s1_q.b_hi;
   assign h_a[0]   = PW'(in_a[HALF-1:0]);
   assign h_b[0]   = PW'(b_lo_eff);
   assign h_cin[0] = in_sub;
   assign h_a[1]   = PW'(s1_q.a_hi);
   assign h_b[1]   = PW'(b_hi_eff);
   assign h_cin[1] = s1_q.ctrl.half_cout;

   for (genvar h = 0; h < 2; h++) begin : g_half
      logic [NGH:0]   gc;
      logic [NGH-1:0] gp, gg;
      logic [PW:0]    ci;

      assign gc[0] = h_cin[h];
      for (genvar k = 0; k < NGH; k++) begin : g_grp
         cla_group4 u_grp (
            .a   (h_a[h][CLA_GROUP_W*k +: CLA_GROUP_W]),
            .b   (h_b[h][CLA_GROUP_W*k +: CLA_GROUP_W]),
            .cin (gc[k]),
            .c   (ci[CLA_GROUP_W*k+1 +: CLA_GROUP_W-1]),
            .p   (gp[k]),
            .g   (gg[k])
         );
         assign gc[k+1]           = gg[k] | (gp[k] & gc[k]);
         assign ci[CLA_GROUP_W*k] = gc[k];
      end
      assign ci[PW]    = gc[NGH];
      assign h_sum[h]  = h_a[h] ^ h_b[h] ^ ci[PW-1:0];
      assign h_cout[h] = ci[HALF];
      if (h == 1) begin : g_msb
         assign hi_cmsb = ci[HALF-1];
      end
   end

   always_comb begin
      s1_d                = '0;
      s1_d.sum_lo         = h_sum[0][HALF-1:0];
      s1_d.a_hi           = in_a[WIDTH-1:HALF];
      s1_d.b_hi           = in_b[WIDTH-1:HALF];
      s1_d.ctrl.half_cout = h_cout[0];
      s1_d.ctrl.sub       = in_sub;
`ifdef PIPELINED_CLA_ADDER_SAT_EN
      s1_d.ctrl.sat       = in_sat;
`endif
   end

   always_comb begin
      ovfl_d = hi_cmsb ^ h_cout[1];
      sum_d  = {h_sum[1][HALF-1:0], s1_q.sum_lo};
`ifdef PIPELINED_CLA_ADDER_SAT_EN
      if (s1_q.ctrl.sat && ovfl_d)
         sum_d = WIDTH'(sat_value(s1_q.a_hi[HALF-1], WIDTH));
`endif
   end

`ifndef PIPELINED_CLA_ADDER_SAT_EN
   logic unused_sat;
   assign unused_sat = in_sat;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (s1_ready) begin
         s1_valid <= in_valid;
         if (in_valid)
            s1_q <= s1_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         out_sum  <= '0;
         out_cout <= 1'b0;
         out_ovfl <= 1'b0;
         out_zero <= 1'b0;
      end else if (s2_ready) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_sum  <= sum_d;
            out_cout <= h_cout[1];
            out_ovfl <= ovfl_d;
            out_zero <= (sum_d == '0);
         end
      end
   end

   assign out_valid = s2_valid;

endmodule
